// File: rtl/top_k_tx_packetizer.sv
// Top-k TX packetizer: takes one 512-bit result beat plus its session ID,
// requests a TX slot, waits for TX status, then sends a single payload beat.
// Status errors and status timeouts trigger a bounded retry with backoff.
// After the last retry fails, the response is dropped.
//
// Handshake rule for every AXI-Stream port: a transfer happens on a rising
// clk edge where VALID and READY are both high. Once a VALID output is
// raised, it and its DATA stay stable until that transfer. No VALID output
// depends on the matching READY input.
module top_k_tx_packetizer #(
    parameter int PKT_BYTES   = 64,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF     = 16,
    parameter int STS_TIMEOUT = 1023
) (
    input  logic         clk,
    input  logic         ap_rst_n,
    input  logic [511:0] s_TDATA,
    input  logic         s_TVALID,
    output logic         s_TREADY,
    input  logic [31:0]  meta_TDATA,
    input  logic         meta_TVALID,
    output logic         meta_TREADY,
    output logic [31:0]  tx_meta_TDATA,
    output logic         tx_meta_TVALID,
    input  logic         tx_meta_TREADY,
    input  logic [31:0]  tx_status_TDATA,
    input  logic         tx_status_TVALID,
    output logic         tx_status_TREADY,
    output logic [511:0] tx_TDATA,
    output logic [63:0]  tx_TKEEP,
    output logic         tx_TLAST,
    output logic         tx_TVALID,
    input  logic         tx_TREADY,
    output logic [31:0]  sent_cnt,
    output logic [15:0]  drop_cnt,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT_STS, DATA, BACKOFF_W, DROP
    } state_e;

    localparam logic [63:0] KEEP_MASK = {64{1'b1}} >> (64 - PKT_BYTES);
    localparam logic [15:0] LEN       = 16'(PKT_BYTES);
    localparam logic [15:0] TMO_LAST  = 16'(STS_TIMEOUT - 1);
    localparam logic [15:0] BO_LAST   = 16'(BACKOFF - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_e         state_q, state_d;
    logic [511:0]   data_q, data_d;
    logic [15:0]    sess_q, sess_d;
    logic [7:0]     retry_q, retry_d;
    logic [15:0]    cnt_q, cnt_d;      // status timeout in WAIT_STS, backoff in BACKOFF_W
    logic [31:0]    sent_q, sent_d;
    logic [15:0]    drop_q, drop_d;
    logic           accept;
    logic           fail;

    // Status length/session and the upper meta bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{tx_status_TDATA[29:0], meta_TDATA[31:16]};

    // Take a result and its session together, only when both are offered.
    // Gating with ap_rst_n keeps both readies low while reset is held.
    assign accept = ap_rst_n & (state_q == IDLE) & s_TVALID & meta_TVALID;

    assign s_TREADY         = accept;
    assign meta_TREADY      = accept;
    assign tx_meta_TVALID   = (state_q == REQ);
    assign tx_meta_TDATA    = (state_q == REQ) ? {LEN, sess_q} : 32'd0;
    assign tx_status_TREADY = (state_q == WAIT_STS);
    assign tx_TVALID        = (state_q == DATA);
    assign tx_TDATA         = (state_q == DATA) ? data_q : 512'd0;
    assign tx_TKEEP         = (state_q == DATA) ? KEEP_MASK : 64'd0;
    assign tx_TLAST         = (state_q == DATA);
    assign sent_cnt         = sent_q;
    assign drop_cnt         = drop_q;
    assign busy             = (state_q != IDLE);

    // Next-state logic for the FSM, holding registers, retry logic and counters.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sess_d  = sess_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        drop_d  = drop_q;
        fail    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = s_TDATA;
                    sess_d  = meta_TDATA[15:0];
                    state_d = REQ;
                end
            end
            REQ: begin
                if (tx_meta_TREADY) begin
                    cnt_d   = 16'd0;
                    state_d = WAIT_STS;
                end
            end
            WAIT_STS: begin
                if (tx_status_TVALID) begin
                    if (tx_status_TDATA[31:30] != 2'b00) fail = 1'b1;
                    else state_d = DATA;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 8'd1;
                        cnt_d   = 16'd0;
                        state_d = BACKOFF_W;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            BACKOFF_W: begin
                if (cnt_q == BO_LAST) state_d = REQ;
                else cnt_d = cnt_q + 16'd1;
            end
            DATA: begin
                if (tx_TREADY) begin
                    sent_d  = sent_q + 32'd1;
                    retry_d = 8'd0;
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                retry_d = 8'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any response in flight.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
            data_q  <= 512'd0;
            sess_q  <= 16'd0;
            retry_q <= 8'd0;
            cnt_q   <= 16'd0;
            sent_q  <= 32'd0;
            drop_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sess_q  <= sess_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_top_k_tx_packetizer.sv
// Bench for top_k_tx_packetizer. The main instance uses the default
// parameters. A second instance with PKT_BYTES=32 shares every input.
// Inputs are driven, and outputs sampled, on the falling clock edge.
module tb_top_k_tx_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         ap_rst_n;
    logic [511:0] s_TDATA;
    logic         s_TVALID, s_TREADY;
    logic [31:0]  meta_TDATA;
    logic         meta_TVALID, meta_TREADY;
    logic [31:0]  tx_meta_TDATA;
    logic         tx_meta_TVALID, tx_meta_TREADY;
    logic [31:0]  tx_status_TDATA;
    logic         tx_status_TVALID, tx_status_TREADY;
    logic [511:0] tx_TDATA;
    logic [63:0]  tx_TKEEP;
    logic         tx_TLAST, tx_TVALID, tx_TREADY;
    logic [31:0]  sent_cnt;
    logic [15:0]  drop_cnt;
    logic         busy;

    logic         b_s_TREADY, b_meta_TREADY, b_tx_meta_TVALID, b_tx_status_TREADY;
    logic [31:0]  b_tx_meta_TDATA;
    logic [511:0] b_tx_TDATA;
    logic [63:0]  b_tx_TKEEP;
    logic         b_tx_TLAST, b_tx_TVALID, b_busy;
    logic [31:0]  b_sent_cnt;
    logic [15:0]  b_drop_cnt;

    top_k_tx_packetizer dut (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
        .meta_TDATA(meta_TDATA), .meta_TVALID(meta_TVALID), .meta_TREADY(meta_TREADY),
        .tx_meta_TDATA(tx_meta_TDATA), .tx_meta_TVALID(tx_meta_TVALID), .tx_meta_TREADY(tx_meta_TREADY),
        .tx_status_TDATA(tx_status_TDATA), .tx_status_TVALID(tx_status_TVALID),
        .tx_status_TREADY(tx_status_TREADY),
        .tx_TDATA(tx_TDATA), .tx_TKEEP(tx_TKEEP), .tx_TLAST(tx_TLAST),
        .tx_TVALID(tx_TVALID), .tx_TREADY(tx_TREADY),
        .sent_cnt(sent_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    top_k_tx_packetizer #(.PKT_BYTES(32)) dut32 (
        .clk(clk), .ap_rst_n(ap_rst_n),
        .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(b_s_TREADY),
        .meta_TDATA(meta_TDATA), .meta_TVALID(meta_TVALID), .meta_TREADY(b_meta_TREADY),
        .tx_meta_TDATA(b_tx_meta_TDATA), .tx_meta_TVALID(b_tx_meta_TVALID),
        .tx_meta_TREADY(tx_meta_TREADY),
        .tx_status_TDATA(tx_status_TDATA), .tx_status_TVALID(tx_status_TVALID),
        .tx_status_TREADY(b_tx_status_TREADY),
        .tx_TDATA(b_tx_TDATA), .tx_TKEEP(b_tx_TKEEP), .tx_TLAST(b_tx_TLAST),
        .tx_TVALID(b_tx_TVALID), .tx_TREADY(tx_TREADY),
        .sent_cnt(b_sent_cnt), .drop_cnt(b_drop_cnt), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int meta_hs = 0;
    int tx_hs = 0;

    // Handshake monitor.
    always @(posedge clk) begin
        if (tx_meta_TVALID && tx_meta_TREADY) meta_hs = meta_hs + 1;
        if (tx_TVALID && tx_TREADY) tx_hs = tx_hs + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_meta_TVALID;
            1:       return tx_status_TREADY;
            2:       return tx_TVALID;
            default: return !busy;
        endcase
    endfunction

    // Advance negedges until the selected condition holds; cnt = edges advanced.
    task automatic wait_sig(input string name, input int sel, input int max, output int cnt);
        cnt = 0;
        while (!sig(sel) && cnt < max) begin
            @(negedge clk);
            cnt++;
        end
        if (!sig(sel)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles", name, max);
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        s_TVALID = 1'b0;
        meta_TVALID = 1'b0;
        tx_meta_TREADY = 1'b1;
        tx_status_TVALID = 1'b0;
        tx_status_TDATA = 32'd0;
        tx_TREADY = 1'b1;
        repeat (3) @(negedge clk);
        ap_rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offer one result in IDLE; returns at the first REQ negedge (N+1).
    task automatic offer(input logic [15:0] sess, input logic [7:0] b);
        s_TDATA = {64{b}};
        meta_TDATA = {16'hBEEF, sess};
        s_TVALID = 1'b1;
        meta_TVALID = 1'b1;
        #1;
        chk("s_TREADY_accept", 512'(s_TREADY), 512'd1);
        chk("meta_TREADY_accept", 512'(meta_TREADY), 512'd1);
        @(negedge clk);
        s_TVALID = 1'b0;
        meta_TVALID = 1'b0;
    endtask

    task automatic send_status(input logic [1:0] err);
        tx_status_TDATA = {err, 14'd64, 16'h0000};
        tx_status_TVALID = 1'b1;
        @(negedge clk);
        tx_status_TVALID = 1'b0;
    endtask

    task automatic run_single(input logic [15:0] sess, input logic [7:0] b);
        int c;
        offer(sess, b);
        wait_sig("single_sts", 1, 20, c);
        send_status(2'b00);
        wait_sig("single_idle", 3, 20, c);
    endtask

    typedef struct {
        logic [15:0] sess;
        logic [7:0]  b;
        logic [31:0] exp_meta;
        logic [31:0] exp_meta_b;
        logic [31:0] exp_sent;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int c;
        int m0, t0;
        logic ok;

        vecs[0] = '{16'h0042, 8'hA5, 32'h0040_0042, 32'h0020_0042, 32'd1};
        vecs[1] = '{16'h1234, 8'h3C, 32'h0040_1234, 32'h0020_1234, 32'd2};
        vecs[2] = '{16'hFFFF, 8'h00, 32'h0040_FFFF, 32'h0020_FFFF, 32'd3};

        // Reset with every valid input high: outputs must all be quiet.
        ap_rst_n = 1'b1;
        s_TDATA = {64{8'h77}};
        meta_TDATA = 32'h0000_0001;
        s_TVALID = 1'b1;
        meta_TVALID = 1'b1;
        tx_meta_TREADY = 1'b1;
        tx_status_TDATA = 32'd0;
        tx_status_TVALID = 1'b1;
        tx_TREADY = 1'b1;
        #2 ap_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_TREADY", 512'(s_TREADY), 512'd0);
        chk("rst_meta_TREADY", 512'(meta_TREADY), 512'd0);
        chk("rst_tx_meta_TVALID", 512'(tx_meta_TVALID), 512'd0);
        chk("rst_tx_status_TREADY", 512'(tx_status_TREADY), 512'd0);
        chk("rst_tx_TVALID", 512'(tx_TVALID), 512'd0);
        chk("rst_tx_TDATA", tx_TDATA, 512'd0);
        chk("rst_tx_TKEEP", 512'(tx_TKEEP), 512'd0);
        chk("rst_tx_TLAST", 512'(tx_TLAST), 512'd0);
        chk("rst_sent_cnt", 512'(sent_cnt), 512'd0);
        chk("rst_drop_cnt", 512'(drop_cnt), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        do_reset();

        // Only the result is valid, without meta: nothing may be consumed.
        s_TVALID = 1'b1;
        #1;
        chk("half_s_TREADY", 512'(s_TREADY), 512'd0);
        chk("half_meta_TREADY", 512'(meta_TREADY), 512'd0);
        @(negedge clk);
        chk("half_busy", 512'(busy), 512'd0);
        s_TVALID = 1'b0;

        // Table-driven single responses, all readies high.
        for (int i = 0; i < 3; i++) begin
            offer(vecs[i].sess, vecs[i].b);
            chk("vec_meta_valid", 512'(tx_meta_TVALID), 512'd1);
            chk("vec_meta_data", 512'(tx_meta_TDATA), 512'(vecs[i].exp_meta));
            chk("vec_meta_data_b32", 512'(b_tx_meta_TDATA), 512'(vecs[i].exp_meta_b));
            chk("vec_s_TREADY_busy", 512'(s_TREADY), 512'd0);
            @(negedge clk);
            chk("vec_sts_ready", 512'(tx_status_TREADY), 512'd1);
            send_status(2'b00);
            chk("vec_tx_valid", 512'(tx_TVALID), 512'd1);
            chk("vec_tx_data", tx_TDATA, {64{vecs[i].b}});
            chk("vec_tx_keep", 512'(tx_TKEEP), 512'(64'hFFFF_FFFF_FFFF_FFFF));
            chk("vec_tx_keep_b32", 512'(b_tx_TKEEP), 512'(64'h0000_0000_FFFF_FFFF));
            chk("vec_tx_last", 512'(tx_TLAST), 512'd1);
            @(negedge clk);
            chk("vec_idle", 512'(busy), 512'd0);
            chk("vec_sent_cnt", 512'(sent_cnt), 512'(vecs[i].exp_sent));
        end

        // Backpressure on tx_meta and tx data; stray status ignored outside WAIT_STS.
        do_reset();
        m0 = meta_hs;
        t0 = tx_hs;
        tx_meta_TREADY = 1'b0;
        tx_TREADY = 1'b0;
        offer(16'h0042, 8'hA5);
        tx_status_TDATA = 32'h0;
        tx_status_TVALID = 1'b1;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!tx_meta_TVALID || tx_meta_TDATA !== 32'h0040_0042 || tx_status_TREADY) ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_meta_stable", 512'(ok), 512'd1);
        tx_status_TVALID = 1'b0;
        tx_meta_TREADY = 1'b1;
        @(negedge clk);
        tx_meta_TREADY = 1'b0;
        chk("bp_meta_hs", 512'(meta_hs - m0), 512'd1);
        send_status(2'b00);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!tx_TVALID || tx_TDATA !== {64{8'hA5}} || !tx_TLAST) ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_tx_stable", 512'(ok), 512'd1);
        tx_TREADY = 1'b1;
        @(negedge clk);
        chk("bp_sent_cnt", 512'(sent_cnt), 512'd1);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (tx_TVALID) ok = 1'b0;
            @(negedge clk);
        end
        chk("bp_no_dup", 512'(ok), 512'd1);
        chk("bp_tx_hs", 512'(tx_hs - t0), 512'd1);
        tx_meta_TREADY = 1'b1;

        // Two status errors, then success.
        do_reset();
        m0 = meta_hs;
        t0 = tx_hs;
        offer(16'h0042, 8'hA5);
        for (int k = 0; k < 2; k++) begin
            wait_sig("retry_sts", 1, 20, c);
            send_status(2'b01);
            wait_sig("retry_gap", 0, 100, c);
            chk("retry_backoff_gap", 512'(c), 512'd16);
        end
        wait_sig("retry_sts_ok", 1, 20, c);
        send_status(2'b00);
        wait_sig("retry_idle", 3, 20, c);
        chk("retry_meta_hs", 512'(meta_hs - m0), 512'd3);
        chk("retry_tx_hs", 512'(tx_hs - t0), 512'd1);
        chk("retry_drop_cnt", 512'(drop_cnt), 512'd0);
        chk("retry_sent_cnt", 512'(sent_cnt), 512'd1);

        // Four errors exhaust the retries and drop the response.
        do_reset();
        t0 = tx_hs;
        offer(16'h0042, 8'hA5);
        for (int k = 0; k < 4; k++) begin
            wait_sig("drop_sts", 1, 100, c);
            send_status(2'b10);
        end
        chk("drop_state_busy", 512'(busy), 512'd1);
        chk("drop_no_meta", 512'(tx_meta_TVALID), 512'd0);
        @(negedge clk);
        chk("drop_idle", 512'(busy), 512'd0);
        chk("drop_cnt_1", 512'(drop_cnt), 512'd1);
        chk("drop_no_tx", 512'(tx_hs - t0), 512'd0);
        run_single(16'h0055, 8'h5A);
        chk("drop_next_sent", 512'(sent_cnt), 512'd1);
        chk("drop_next_drop", 512'(drop_cnt), 512'd1);

        // Status never arrives: timeout takes the retry path.
        do_reset();
        m0 = meta_hs;
        offer(16'h0042, 8'h5A);
        wait_sig("tmo_sts", 1, 20, c);
        wait_sig("tmo_retry", 0, 1200, c);
        chk("tmo_gap_in_range", 512'((c >= 1039) && (c <= 1040)), 512'd1);
        chk("tmo_meta_b32", 512'(b_tx_meta_TDATA), 512'(32'h0020_0042));
        @(negedge clk);
        send_status(2'b00);
        chk("tmo_keep_b32", 512'(b_tx_TKEEP), 512'(64'h0000_0000_FFFF_FFFF));
        chk("tmo_keep_64", 512'(tx_TKEEP), 512'(64'hFFFF_FFFF_FFFF_FFFF));
        @(negedge clk);
        chk("tmo_meta_hs", 512'(meta_hs - m0), 512'd2);
        chk("tmo_sent", 512'(sent_cnt), 512'd1);
        chk("tmo_sent_b32", 512'(b_sent_cnt), 512'd1);

        // Asynchronous reset while a data beat is stalled.
        do_reset();
        run_single(16'h0007, 8'h11);
        chk("arst_pre_sent", 512'(sent_cnt), 512'd1);
        tx_TREADY = 1'b0;
        offer(16'h0008, 8'h22);
        wait_sig("arst_sts", 1, 20, c);
        send_status(2'b00);
        chk("arst_in_data", 512'(tx_TVALID), 512'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", 512'(tx_TVALID), 512'd0);
        chk("arst_tx_data", tx_TDATA, 512'd0);
        chk("arst_sent", 512'(sent_cnt), 512'd0);
        chk("arst_busy", 512'(busy), 512'd0);
        @(negedge clk);
        ap_rst_n = 1'b1;
        tx_TREADY = 1'b1;
        @(negedge clk);
        run_single(16'h0009, 8'h33);
        chk("arst_resume_sent", 512'(sent_cnt), 512'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
